// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Sits behind the UART receiver and turns its byte strobe into framed packets:
//   HEADER, LEN, LEN payload bytes, CSUM. A frame whose checksum matches is
//   buffered and then released on a valid/ready byte stream. Frames with a bad
//   length or checksum are dropped and reported on frame_err/err_code.
//
//   Ports
//     CLK        in   clock
//     RST        in   synchronous reset, active-high
//     in_data    in   received byte (uart_rx rx_data)
//     in_valid   in   one-cycle byte strobe (uart_rx po_flag), no backpressure
//     out_data   out  payload byte, 0 whenever out_valid is low
//     out_valid  out  out_data valid
//     out_ready  in   sink accepts the byte when out_valid && out_ready
//     out_last   out  final payload byte of the frame
//     frame_ok   out  one-cycle pulse: checksum good, drain starts
//     frame_err  out  one-cycle pulse: frame or byte dropped
//     err_code   out  with frame_err: 0 overrun, 1 bad LEN, 2 checksum, 3 timeout
//     busy       out  high in every state except IDLE
//
//   Build option
//     UART_FRAME_TIMEOUT_EN  enables the inter-byte timeout (err_code 3).
//                            Without it a stalled frame waits forever.

module uart_frame_parser #(
    parameter int         DATAWIDTH    = 8,
    parameter int         PTR_WIDTH    = 4,
    parameter logic [7:0] HEADER       = 8'h55,
    parameter int         TIMEOUT_CYC  = 600,
    parameter int         TO_CNT_WIDTH = 12
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic                 busy
);

    localparam int                   MAX_LEN      = 2**PTR_WIDTH;
    localparam int                   LEN_W        = PTR_WIDTH + 1;
    localparam logic [DATAWIDTH-1:0] MAX_LEN_BYTE = DATAWIDTH'(MAX_LEN);
    localparam logic [1:0]           ERR_OVERRUN  = 2'd0;
    localparam logic [1:0]           ERR_LEN      = 2'd1;
    localparam logic [1:0]           ERR_CSUM     = 2'd2;
    localparam logic [1:0]           ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [PTR_WIDTH-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_WIDTH-1:0]   rdPtr_q, rdPtr_d;
    logic [DATAWIDTH-1:0]   sum_q, sum_d;
    logic                   frameOk_q, frameOk_d;
    logic                   frameErr_q, frameErr_d;
    logic [1:0]             errCode_q, errCode_d;
    logic                   bufWrEn;
    logic                   lastWr;
    logic                   lastRd;
    logic                   toExpire;
    logic [DATAWIDTH-1:0]   buffer [MAX_LEN];

    // The write pointer marks the LEN-th payload byte, the read pointer the
    // final byte to drain; both compare against the stored length minus one.
    assign lastWr = ({1'b0, wrPtr_q} == (len_q - LEN_W'(1)));
    assign lastRd = ({1'b0, rdPtr_q} == (len_q - LEN_W'(1)));

`ifdef UART_FRAME_TIMEOUT_EN
    logic [TO_CNT_WIDTH-1:0] toCnt_q, toCnt_d;
    logic                    timedState;

    // Inter-byte watchdog: restarts on every strobe and only runs while a frame
    // is being collected. The register lags the cycle count by one, so expiry
    // is decided when the count is about to reach TIMEOUT_CYC-1. A byte that
    // lands in the expiry cycle wins and is processed normally.
    always_comb begin
        timedState = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
        toCnt_d    = '0;
        if (timedState && !in_valid) begin
            toCnt_d = toCnt_q + TO_CNT_WIDTH'(1);
        end
    end

    assign toExpire = timedState && !in_valid && (toCnt_q == TO_CNT_WIDTH'(TIMEOUT_CYC - 2));

    // Watchdog counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            toCnt_q <= '0;
        end else begin
            toCnt_q <= toCnt_d;
        end
    end
`else
    // Timeout compiled out: expiry never fires. The timeout parameters are
    // still folded in here so the parameter list is the same in both builds.
    localparam bit TIMEOUT_CFG_OK = (TIMEOUT_CYC > 1) && (TO_CNT_WIDTH > 0);
    assign toExpire = 1'b0 & TIMEOUT_CFG_OK;
`endif

    // State and datapath registers. Reset clears everything so a reset in the
    // middle of a frame or a drain simply abandons it without reporting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            sum_q      <= '0;
            frameOk_q  <= 1'b0;
            frameErr_q <= 1'b0;
            errCode_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            sum_q      <= sum_d;
            frameOk_q  <= frameOk_d;
            frameErr_q <= frameErr_d;
            errCode_q  <= errCode_d;
        end
    end

    // Payload buffer. Contents need no reset because nothing is read outside
    // DRAIN and every drained location was written by the current frame.
    always_ff @(posedge CLK) begin
        if (bufWrEn) begin
            buffer[wrPtr_q] <= in_data;
        end
    end

    // Next-state and datapath logic. Every transition except the drain exit
    // and the watchdog is triggered by an incoming byte. The checksum covers
    // LEN and the payload but not the header.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        sum_d      = sum_q;
        frameOk_d  = 1'b0;
        frameErr_d = 1'b0;
        errCode_d  = '0;
        bufWrEn    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && (in_data == HEADER)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (in_valid) begin
                    if ((in_data == '0) || (in_data > MAX_LEN_BYTE)) begin
                        frameErr_d = 1'b1;
                        errCode_d  = ERR_LEN;
                        state_d    = ST_IDLE;
                    end else begin
                        len_d   = in_data[LEN_W-1:0];
                        sum_d   = in_data;
                        wrPtr_d = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_valid) begin
                    bufWrEn = 1'b1;
                    sum_d   = sum_q + in_data;
                    wrPtr_d = wrPtr_q + PTR_WIDTH'(1);
                    if (lastWr) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (in_valid) begin
                    if (in_data == sum_q) begin
                        frameOk_d = 1'b1;
                        rdPtr_d   = '0;
                        state_d   = ST_DRAIN;
                    end else begin
                        frameErr_d = 1'b1;
                        errCode_d  = ERR_CSUM;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                // Bytes arriving while draining are dropped; the buffered frame
                // carries on untouched and a dropped header is not re-parsed.
                if (in_valid) begin
                    frameErr_d = 1'b1;
                    errCode_d  = ERR_OVERRUN;
                end
                if (out_ready) begin
                    if (lastRd) begin
                        state_d = ST_IDLE;
                    end else begin
                        rdPtr_d = rdPtr_q + PTR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (toExpire) begin
            frameErr_d = 1'b1;
            errCode_d  = ERR_TIMEOUT;
            state_d    = ST_IDLE;
        end
    end

    // Outputs come only from registers and the buffer, never from in_*.
    // out_valid tracks DRAIN, so it rises with frame_ok and falls the cycle
    // after the last handshake; out_data is forced to 0 outside DRAIN.
    always_comb begin
        out_valid = (state_q == ST_DRAIN);
        out_data  = out_valid ? buffer[rdPtr_q] : '0;
        out_last  = out_valid && lastRd;
        busy      = (state_q != ST_IDLE);
        frame_ok  = frameOk_q;
        frame_err = frameErr_q;
        err_code  = errCode_q;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed frames plus randomized frames. The
// reference is a byte-list view of a frame: payload held in a queue, checksum
// computed as LEN plus payload modulo 256, and length validity as 1..16.

module tb_uart_frame_parser;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expPayload [$];
    logic [7:0] ovrBytes [4] = '{8'h55, 8'h01, 8'hAA, 8'hAB};
    logic [7:0] lenByte;
    logic [7:0] adj;
    logic [7:0] junk;
    int         sel;
    bit         errSeen;

    // 10 ns clock.
    always #5 CLK = ~CLK;

    uart_frame_parser dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    // Hard stop in case something hangs outside the bounded loops.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One-cycle byte strobe after an optional idle gap. Returns one cycle after
    // the strobe was sampled, which is when registered flags become visible.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge CLK);
        @(posedge CLK);
        #1;
        in_data  = b;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Drain the expected payload with a random ready pattern, checking data,
    // hold-while-stalled, out_last, and that out_valid/busy drop afterwards.
    task automatic drainFrame(input int readyPct);
        int  idx    = 0;
        int  cycles = 0;
        int  n      = expPayload.size();
        bit  first  = 1'b1;
        while ((idx < n) && (cycles < 500)) begin
            @(posedge CLK);
            #1;
            out_ready = ($urandom_range(99) < readyPct);
            @(negedge CLK);
            if (first) begin
                checkOutput("ok_pulse_width", 32'(frame_ok), 32'd0);
                first = 1'b0;
            end
            checkOutput("drain_valid", 32'(out_valid), 32'd1);
            checkOutput("drain_data", 32'(out_data), 32'(expPayload[idx]));
            if (out_ready) begin
                checkOutput("drain_last", 32'(out_last), 32'(idx == n - 1));
                idx++;
            end
            cycles++;
        end
        checkOutput("drain_count", 32'(idx), 32'(n));
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        checkOutput("drain_end_valid", 32'(out_valid), 32'd0);
        checkOutput("drain_end_busy", 32'(busy), 32'd0);
    endtask

    // Send one frame built from expPayload; csumAdj != 0 corrupts the checksum.
    task automatic runFrame(input logic [7:0] lenB, input logic [7:0] csumAdj, input int maxGap,
                            input bit doDrain, input int readyPct);
        logic [7:0] sum;
        bit         lenOk;
        lenOk = (lenB != 8'd0) && (lenB <= 8'd16);
        applyStimulus(8'h55, $urandom_range(maxGap));
        applyStimulus(lenB, $urandom_range(maxGap));
        if (!lenOk) begin
            checkOutput("len_err_flag", 32'(frame_err), 32'd1);
            checkOutput("len_err_code", 32'(err_code), 32'd1);
            checkOutput("len_err_busy", 32'(busy), 32'd0);
            return;
        end
        sum = lenB;
        foreach (expPayload[i]) begin
            applyStimulus(expPayload[i], $urandom_range(maxGap));
            sum = sum + expPayload[i];
        end
        checkOutput("payload_busy", 32'(busy), 32'd1);
        applyStimulus(8'(sum + csumAdj), $urandom_range(maxGap));
        if (csumAdj == 8'd0) begin
            checkOutput("ok_flag", 32'(frame_ok), 32'd1);
            checkOutput("ok_no_err", 32'(frame_err), 32'd0);
            checkOutput("ok_valid", 32'(out_valid), 32'd1);
            checkOutput("ok_first_data", 32'(out_data), 32'(expPayload[0]));
            if (doDrain) drainFrame(readyPct);
        end else begin
            checkOutput("csum_err_flag", 32'(frame_err), 32'd1);
            checkOutput("csum_err_code", 32'(err_code), 32'd2);
            checkOutput("csum_no_ok", 32'(frame_ok), 32'd0);
            checkOutput("csum_no_valid", 32'(out_valid), 32'd0);
            checkOutput("csum_busy", 32'(busy), 32'd0);
            @(negedge CLK);
            checkOutput("csum_no_valid_later", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic pulseReset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_frame_ok", 32'(frame_ok), 32'd0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
        checkOutput("rst_err_code", 32'(err_code), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        RST = 1'b0;

        // Basic good frame: 55 03 11 22 33 69.
        expPayload = '{8'h11, 8'h22, 8'h33};
        runFrame(8'd3, 8'd0, 0, 1'b1, 100);

        // Same frame with checksum 68, then a good frame.
        runFrame(8'd3, 8'hFF, 0, 1'b0, 100);
        runFrame(8'd3, 8'd0, 2, 1'b1, 50);

        // Length 0 and length 17, then junk A0 and 55 01 7F 80.
        expPayload.delete();
        runFrame(8'd0, 8'd0, 0, 1'b0, 100);
        runFrame(8'h11, 8'd0, 0, 1'b0, 100);
        applyStimulus(8'hA0, 0);
        checkOutput("idle_junk_no_err", 32'(frame_err), 32'd0);
        checkOutput("idle_junk_busy", 32'(busy), 32'd0);
        expPayload = '{8'h7F};
        runFrame(8'd1, 8'd0, 0, 1'b1, 100);

        // Overrun during a stalled drain leaves the buffer intact.
        expPayload = '{8'hC1, 8'hC2, 8'hC3};
        runFrame(8'd3, 8'd0, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ovrBytes[i], 0);
            checkOutput("ovr_err_flag", 32'(frame_err), 32'd1);
            checkOutput("ovr_err_code", 32'(err_code), 32'd0);
            checkOutput("ovr_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("ovr_hold_data", 32'(out_data), 32'hC1);
        end
        drainFrame(100);

        // Maximum length frame.
        expPayload.delete();
        for (int i = 0; i < 16; i++) expPayload.push_back(8'($urandom));
        runFrame(8'd16, 8'd0, 1, 1'b1, 70);

`ifdef UART_FRAME_TIMEOUT_EN
        // Stall after one payload byte: error decided in cycle 599, seen in 600.
        applyStimulus(8'h55, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h11, 0);
        repeat (598) @(posedge CLK);
        #1;
        checkOutput("to_not_yet", 32'(frame_err), 32'd0);
        @(posedge CLK);
        #1;
        checkOutput("to_err_flag", 32'(frame_err), 32'd1);
        checkOutput("to_err_code", 32'(err_code), 32'd3);
        checkOutput("to_busy", 32'(busy), 32'd0);
        // Byte arriving in the expiry cycle is accepted.
        applyStimulus(8'h55, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h11, 0);
        repeat (598) @(posedge CLK);
        #1;
        in_data  = 8'h22;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        checkOutput("to_late_byte_no_err", 32'(frame_err), 32'd0);
        checkOutput("to_late_byte_busy", 32'(busy), 32'd1);
        expPayload = '{8'h11, 8'h22};
        applyStimulus(8'h35, 0);
        checkOutput("to_late_frame_ok", 32'(frame_ok), 32'd1);
        drainFrame(100);
`else
        // Without the watchdog a stalled frame just waits, then completes.
        applyStimulus(8'h55, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h11, 0);
        errSeen = 1'b0;
        repeat (700) begin
            @(negedge CLK);
            if (frame_err) errSeen = 1'b1;
        end
        checkOutput("stall_no_err", 32'(errSeen), 32'd0);
        checkOutput("stall_busy", 32'(busy), 32'd1);
        expPayload = '{8'h11, 8'h22};
        applyStimulus(8'h22, 0);
        applyStimulus(8'h35, 0);
        checkOutput("stall_frame_ok", 32'(frame_ok), 32'd1);
        drainFrame(100);
`endif

        // Reset mid-payload, then a fresh frame.
        applyStimulus(8'h55, 0);
        applyStimulus(8'h04, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h02, 0);
        pulseReset();
        checkOutput("rstpay_busy", 32'(busy), 32'd0);
        checkOutput("rstpay_no_err", 32'(frame_err), 32'd0);
        checkOutput("rstpay_valid", 32'(out_valid), 32'd0);
        expPayload = '{8'hDE, 8'hAD};
        runFrame(8'd2, 8'd0, 1, 1'b1, 100);

        // Reset mid-drain, then a fresh frame.
        expPayload = '{8'h01, 8'h02, 8'h03, 8'h04};
        runFrame(8'd4, 8'd0, 0, 1'b0, 0);
        pulseReset();
        checkOutput("rstdrn_valid", 32'(out_valid), 32'd0);
        checkOutput("rstdrn_data", 32'(out_data), 32'd0);
        checkOutput("rstdrn_last", 32'(out_last), 32'd0);
        checkOutput("rstdrn_no_err", 32'(frame_err), 32'd0);
        checkOutput("rstdrn_busy", 32'(busy), 32'd0);
        expPayload = '{8'hBE, 8'hEF, 8'h55};
        runFrame(8'd3, 8'd0, 1, 1'b1, 60);

        // Randomized frames with idle junk, bad lengths and bad checksums.
        for (int f = 0; f < 24; f++) begin
            repeat ($urandom_range(2)) begin
                junk = 8'($urandom);
                if (junk == 8'h55) junk = 8'h56;
                applyStimulus(junk, $urandom_range(2));
                checkOutput("rand_idle_junk", 32'(frame_err), 32'd0);
            end
            sel = $urandom_range(9);
            if (sel == 0)      lenByte = 8'd0;
            else if (sel == 1) lenByte = 8'(17 + $urandom_range(238));
            else               lenByte = 8'(1 + $urandom_range(15));
            expPayload.delete();
            if ((lenByte != 8'd0) && (lenByte <= 8'd16)) begin
                for (int i = 0; i < int'(lenByte); i++) expPayload.push_back(8'($urandom));
            end
            adj = ($urandom_range(3) == 0) ? 8'(1 + $urandom_range(254)) : 8'd0;
            runFrame(lenByte, adj, 3, 1'b1, 30 + $urandom_range(70));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
